// File: rtl/cmp_pkg.sv
// Shared definitions for the comparator-verdict window statistics block.
//   state_t  : window FSM states (IDLE, RUN, DONE)
//   GT/LT/EQ : one-hot verdict codes, ordered {greater, lesser, equal}
package cmp_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [2:0] GT = 3'b100;
  localparam logic [2:0] LT = 3'b010;
  localparam logic [2:0] EQ = 3'b001;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter.
//   clk    : rising-edge clock
//   rst_n  : asynchronous active-low reset, value -> 0
//   clear  : synchronous clear, wins over inc
//   inc    : increment enable; the count sticks at all-ones
//   value  : registered count
module sat_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             inc,
  output logic [WIDTH-1:0] value
);

  function automatic logic [WIDTH-1:0] sat_inc(input logic [WIDTH-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value <= '0;
    end else if (clear) begin
      value <= '0;
    end else if (inc) begin
      value <= sat_inc(value);
    end
  end

endmodule

// File: rtl/cmp_window_stats.sv
// Collects comparator verdict statistics over a window of WINDOW accepted beats.
//   clk, rst_n          : clock, asynchronous active-low reset
//   start               : begins a window (honoured only in IDLE)
//   in_valid / in_ready : beat handshake; transfer when both high
//   greater/lesser/equal: verdict flags of the beat
//   gt/lt/eq/err_count  : saturating per-verdict and malformed-beat counts
//   max_eq_run          : longest run of consecutive equal beats
//   busy                : high in RUN and DONE
//   done                : one-cycle pulse after the last beat of the window
// Counts hold from DONE until the next accepted start.
module cmp_window_stats
  import cmp_pkg::*;
#(
  parameter int WINDOW = 16,
  parameter int CNT_W  = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             greater,
  input  logic             lesser,
  input  logic             equal,
  output logic [CNT_W-1:0] gt_count,
  output logic [CNT_W-1:0] lt_count,
  output logic [CNT_W-1:0] eq_count,
  output logic [CNT_W-1:0] err_count,
  output logic [CNT_W-1:0] max_eq_run,
  output logic             busy,
  output logic             done
);

  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(WINDOW - 1);

  state_t           state;
  logic [CNT_W-1:0] beat_idx;
  logic [CNT_W-1:0] cur_run;
  logic [2:0]       verdict;
  logic             accept;
  logic             clr;
  logic             is_gt, is_lt, is_eq, is_err;

  // Peak of the stored maximum and the run length this equal beat produces;
  // the run length itself is saturated first so the peak never wraps either.
  function automatic logic [CNT_W-1:0] run_peak(input logic [CNT_W-1:0] peak,
                                                input logic [CNT_W-1:0] run);
    logic [CNT_W-1:0] next_run;
    next_run = (&run) ? run : run + 1'b1;
    return (next_run > peak) ? next_run : peak;
  endfunction

  assign verdict = {greater, lesser, equal};
  // in_ready is a register that is high exactly in RUN
  assign accept  = in_valid && in_ready;
  assign clr     = (state == IDLE) && start;
  assign is_gt   = accept && (verdict == GT);
  assign is_lt   = accept && (verdict == LT);
  assign is_eq   = accept && (verdict == EQ);
  assign is_err  = accept && (verdict != GT) && (verdict != LT) && (verdict != EQ);

  sat_counter #(.WIDTH(CNT_W)) u_gt (
    .clk(clk), .rst_n(rst_n), .clear(clr), .inc(is_gt), .value(gt_count)
  );
  sat_counter #(.WIDTH(CNT_W)) u_lt (
    .clk(clk), .rst_n(rst_n), .clear(clr), .inc(is_lt), .value(lt_count)
  );
  sat_counter #(.WIDTH(CNT_W)) u_eq (
    .clk(clk), .rst_n(rst_n), .clear(clr), .inc(is_eq), .value(eq_count)
  );
  sat_counter #(.WIDTH(CNT_W)) u_err (
    .clk(clk), .rst_n(rst_n), .clear(clr), .inc(is_err), .value(err_count)
  );
  // Any non-equal accepted beat (error beats included) breaks the run.
  sat_counter #(.WIDTH(CNT_W)) u_run (
    .clk(clk), .rst_n(rst_n), .clear(clr || (accept && !is_eq)), .inc(is_eq),
    .value(cur_run)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      in_ready   <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      beat_idx   <= '0;
      max_eq_run <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state      <= RUN;
            in_ready   <= 1'b1;
            busy       <= 1'b1;
            beat_idx   <= '0;
            max_eq_run <= '0;
          end
        end
        RUN: begin
          if (accept) begin
            beat_idx <= beat_idx + 1'b1;
            if (is_eq) begin
              max_eq_run <= run_peak(max_eq_run, cur_run);
            end
            if (beat_idx == LAST_BEAT) begin
              state    <= DONE;
              in_ready <= 1'b0;
              done     <= 1'b1;
            end
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state    <= IDLE;
          in_ready <= 1'b0;
          busy     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cmp_window_stats.sv
module tb_cmp_window_stats;
  import cmp_pkg::*;

  localparam int W   = 4;
  localparam int CW  = 8;
  localparam int SW  = 3;
  localparam int SCW = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // main instance
  logic          start = 1'b0, in_valid = 1'b0, in_ready;
  logic          greater = 1'b0, lesser = 1'b0, equal = 1'b0;
  logic [CW-1:0] gt_count, lt_count, eq_count, err_count, max_eq_run;
  logic          busy, done;

  cmp_window_stats #(.WINDOW(W), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .greater(greater), .lesser(lesser), .equal(equal),
    .gt_count(gt_count), .lt_count(lt_count), .eq_count(eq_count),
    .err_count(err_count), .max_eq_run(max_eq_run), .busy(busy), .done(done)
  );

  // narrow instance at the top of its legal window range
  logic           s_start = 1'b0, s_in_valid = 1'b0, s_in_ready;
  logic           s_g = 1'b0, s_l = 1'b0, s_e = 1'b0;
  logic [SCW-1:0] s_gt, s_lt, s_eq, s_err, s_max;
  logic           s_busy, s_done;

  cmp_window_stats #(.WINDOW(SW), .CNT_W(SCW)) dut_small (
    .clk(clk), .rst_n(rst_n), .start(s_start), .in_valid(s_in_valid), .in_ready(s_in_ready),
    .greater(s_g), .lesser(s_l), .equal(s_e),
    .gt_count(s_gt), .lt_count(s_lt), .eq_count(s_eq),
    .err_count(s_err), .max_eq_run(s_max), .busy(s_busy), .done(s_done)
  );

  // standalone saturating counter
  logic           sc_clear = 1'b0, sc_inc = 1'b0;
  logic [SCW-1:0] sc_val;

  sat_counter #(.WIDTH(SCW)) dut_sc (
    .clk(clk), .rst_n(rst_n), .clear(sc_clear), .inc(sc_inc), .value(sc_val)
  );

  int tests = 0;
  int fails = 0;

  typedef struct {
    int gt; int lt; int eq; int err; int mx;
  } rec_t;

  rec_t       exp_q[$];
  logic [2:0] win_q[$];
  rec_t       last_exp;
  rec_t       mon_e;

  task automatic check(input string name, input int act, input int exp_v);
    tests++;
    if (act != exp_v) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp_v);
    end
  endtask

  // Reference: tally accepted verdicts of the window with plain arithmetic.
  function automatic rec_t model_window();
    rec_t r;
    int run, cap;
    cap = (1 << CW) - 1;
    r = '{0, 0, 0, 0, 0};
    run = 0;
    foreach (win_q[i]) begin
      case (win_q[i])
        3'b100: begin r.gt++; run = 0; end
        3'b010: begin r.lt++; run = 0; end
        3'b001: begin r.eq++; run++; if (run > r.mx) r.mx = run; end
        default: begin r.err++; run = 0; end
      endcase
    end
    if (r.gt > cap) r.gt = cap;
    if (r.lt > cap) r.lt = cap;
    if (r.eq > cap) r.eq = cap;
    if (r.err > cap) r.err = cap;
    if (r.mx > cap) r.mx = cap;
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
    win_q.delete();
  endtask

  task automatic idle_cycles(input int n);
    in_valid = 1'b0;
    repeat (n) tick();
  endtask

  task automatic send_beat(input logic [2:0] v);
    int n;
    n = 0;
    {greater, lesser, equal} = v;
    in_valid = 1'b1;
    while (!in_ready && n < 100) begin
      tick();
      n++;
    end
    if (!in_ready) begin
      check("beat_accept_timeout", 0, 1);
      in_valid = 1'b0;
      return;
    end
    tick();
    in_valid = 1'b0;
    win_q.push_back(v);
    if (win_q.size() == W) begin
      last_exp = model_window();
      exp_q.push_back(last_exp);
      win_q.delete();
    end
  endtask

  task automatic check_hold(input string tag);
    check({tag, "_gt"},  int'(gt_count),   last_exp.gt);
    check({tag, "_lt"},  int'(lt_count),   last_exp.lt);
    check({tag, "_eq"},  int'(eq_count),   last_exp.eq);
    check({tag, "_err"}, int'(err_count),  last_exp.err);
    check({tag, "_max"}, int'(max_eq_run), last_exp.mx);
  endtask

  // Monitor: every done pulse must match the oldest expected window summary.
  always @(negedge clk) begin
    if (rst_n && done) begin
      if (exp_q.size() == 0) begin
        check("done_unexpected", 1, 0);
      end else begin
        mon_e = exp_q.pop_front();
        check("win_gt",  int'(gt_count),   mon_e.gt);
        check("win_lt",  int'(lt_count),   mon_e.lt);
        check("win_eq",  int'(eq_count),   mon_e.eq);
        check("win_err", int'(err_count),  mon_e.err);
        check("win_max", int'(max_eq_run), mon_e.mx);
        check("done_in_ready", int'(in_ready), 0);
        check("done_busy", int'(busy), 1);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0] v;
    int r;

    // reset state
    repeat (2) @(negedge clk);
    check("rst_in_ready", int'(in_ready), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_gt", int'(gt_count), 0);
    check("rst_max", int'(max_eq_run), 0);
    rst_n = 1'b1;
    tick();

    // 1: back-to-back GT LT EQ EQ, done timing and hold
    do_start();
    check("ready_after_start", int'(in_ready), 1);
    send_beat(GT); send_beat(LT); send_beat(EQ); send_beat(EQ);
    @(negedge clk);
    check("t1_done_high", int'(done), 1);
    check("t1_ready_low", int'(in_ready), 0);
    @(negedge clk);
    check("t1_done_one_cycle", int'(done), 0);
    check("t1_busy_idle", int'(busy), 0);
    repeat (3) @(negedge clk);
    check_hold("t1_hold");

    // 2: error beat breaks the equal run
    do_start();
    send_beat(EQ); send_beat(EQ); send_beat(3'b110); send_beat(EQ);
    idle_cycles(2);

    // 3: in_valid gaps do not break the run or end the window early
    do_start();
    send_beat(EQ); idle_cycles(2); send_beat(EQ); send_beat(EQ); send_beat(GT);
    idle_cycles(2);

    // random windows
    for (int w = 0; w < 8; w++) begin
      do_start();
      for (int b = 0; b < W; b++) begin
        idle_cycles($urandom_range(0, 2));
        r = $urandom_range(0, 9);
        if (r < 3) v = GT;
        else if (r < 5) v = LT;
        else if (r < 9) v = EQ;
        else v = 3'($urandom_range(0, 7));
        send_beat(v);
      end
      idle_cycles($urandom_range(1, 3));
    end

    // 5: start ignored in RUN and DONE, honoured in IDLE
    do_start();
    send_beat(EQ); send_beat(GT);
    start = 1'b1;
    tick();
    start = 1'b0;
    send_beat(EQ); send_beat(EQ);
    start = 1'b1;
    tick();
    start = 1'b0;
    @(negedge clk);
    check("t5_idle_busy", int'(busy), 0);
    check("t5_idle_ready", int'(in_ready), 0);
    check_hold("t5_hold");
    do_start();
    @(negedge clk);
    check("t5_clear_eq", int'(eq_count), 0);
    check("t5_clear_gt", int'(gt_count), 0);
    check("t5_clear_max", int'(max_eq_run), 0);
    check("t5_run_ready", int'(in_ready), 1);

    // 6: asynchronous reset mid-window
    send_beat(EQ); send_beat(LT);
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_eq", int'(eq_count), 0);
    check("t6_lt", int'(lt_count), 0);
    check("t6_busy", int'(busy), 0);
    check("t6_ready", int'(in_ready), 0);
    check("t6_done", int'(done), 0);
    win_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (8) tick();
    @(negedge clk);
    check("t6_after_busy", int'(busy), 0);

    // 4: narrow counts reach all-ones without wrapping
    s_start = 1'b1;
    tick();
    s_start = 1'b0;
    s_in_valid = 1'b1;
    s_g = 1'b1;
    for (int b = 0; b < SW; b++) begin
      check("small_ready", int'(s_in_ready), 1);
      tick();
    end
    s_in_valid = 1'b0;
    s_g = 1'b0;
    @(negedge clk);
    check("small_done", int'(s_done), 1);
    check("small_gt", int'(s_gt), 3);
    check("small_eq", int'(s_eq), 0);
    check("small_err", int'(s_err), 0);

    // sat_counter saturation and clear
    sc_clear = 1'b1;
    tick();
    sc_clear = 1'b0;
    sc_inc = 1'b1;
    repeat (2) tick();
    @(negedge clk);
    check("sc_two", int'(sc_val), 2);
    repeat (3) tick();
    sc_inc = 1'b0;
    @(negedge clk);
    check("sc_saturate", int'(sc_val), 3);
    sc_clear = 1'b1;
    tick();
    sc_clear = 1'b0;
    @(negedge clk);
    check("sc_clear", int'(sc_val), 0);

    repeat (3) tick();
    check("exp_queue_drained", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
